// File: rtl/fwd_stage.sv
// ID/EXE stage register with operand forwarding mux, flush/hold/stall control.
// Optional statistics counters are enabled by defining FWD_STAGE_STATS_EN.
module fwd_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        exe_hold_i,
    input  logic [1:0]  hazard1_i,
    input  logic [1:0]  hazard2_i,
    input  logic [63:0] id_ir_i,
    input  logic [31:0] id_pc_i,
    input  logic [31:0] id_data1_i,
    input  logic [31:0] id_data2_i,
    input  logic [31:0] exe_result_i,
    input  logic [31:0] mem_result_i,
    output logic [63:0] exe_ir_o,
    output logic [31:0] exe_pc_o,
    output logic [31:0] exe_data1_o,
    output logic [31:0] exe_data2_o,
    output logic        exe_valid_o,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] fwd_cnt_o
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    state_t      r_state, w_state_nxt;
    logic        w_load, w_bubble, w_stall_bub;
    logic [31:0] w_op1, w_op2;
    logic        w_fwd_evt;

    // Select 3 is reserved and falls back to the register-file value.
    always_comb begin
        w_op1 = id_data1_i;
        w_op2 = id_data2_i;
        case (hazard1_i)
            2'd1:    w_op1 = mem_result_i;
            2'd2:    w_op1 = exe_result_i;
            default: w_op1 = id_data1_i;
        endcase
        case (hazard2_i)
            2'd1:    w_op2 = mem_result_i;
            2'd2:    w_op2 = exe_result_i;
            default: w_op2 = id_data2_i;
        endcase
    end

    // Flush beats hold, hold beats stall; the decision is the same from either state.
    always_comb begin
        w_state_nxt = RUN;
        w_load      = 1'b0;
        w_bubble    = 1'b0;
        w_stall_bub = 1'b0;
        case (r_state)
            RUN, HOLD: begin
                if (flush_i) begin
                    w_bubble    = 1'b1;
                    w_state_nxt = RUN;
                end else if (exe_hold_i) begin
                    w_state_nxt = HOLD;
                end else if (stall_i) begin
                    w_bubble    = 1'b1;
                    w_stall_bub = 1'b1;
                end else begin
                    w_load = 1'b1;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= RUN;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            exe_ir_o    <= '0;
            exe_pc_o    <= '0;
            exe_data1_o <= '0;
            exe_data2_o <= '0;
            exe_valid_o <= 1'b0;
        end else if (w_bubble) begin
            exe_ir_o    <= '0;
            exe_pc_o    <= '0;
            exe_data1_o <= '0;
            exe_data2_o <= '0;
            exe_valid_o <= 1'b0;
        end else if (w_load) begin
            exe_ir_o    <= id_ir_i;
            exe_pc_o    <= id_pc_i;
            exe_data1_o <= w_op1;
            exe_data2_o <= w_op2;
            exe_valid_o <= (id_ir_i != 64'h0);
        end
    end

    // Selects 1 and 2 are the only real forwards; a NOP never counts.
    assign w_fwd_evt = w_load && (id_ir_i != 64'h0) &&
                       ((hazard1_i[0] ^ hazard1_i[1]) || (hazard2_i[0] ^ hazard2_i[1]));

`ifdef FWD_STAGE_STATS_EN
    logic [15:0] r_stall_cnt, r_fwd_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (w_stall_bub && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_fwd_evt && r_fwd_cnt != 16'hFFFF)     r_fwd_cnt   <= r_fwd_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign fwd_cnt_o   = r_fwd_cnt;
`else
    logic w_unused;
    assign w_unused    = w_stall_bub ^ w_fwd_evt;
    assign stall_cnt_o = 16'h0;
    assign fwd_cnt_o   = 16'h0;
`endif

endmodule

// File: doc/fwd_stage.md
FWD_STAGE -- requirements
Module: fwd_stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed: IR 64, PC 32, data 32, select 2, counters 16.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port stall_i, input, 1 bit: load-use stall from the hazard unit; a bubble is inserted into EXE.
REQ-005 The block SHALL have port flush_i, input, 1 bit: branch/exception flush; kills the instruction entering EXE.
REQ-006 The block SHALL have port exe_hold_i, input, 1 bit: EXE is busy with a multi-cycle op; the stage register is frozen.
REQ-007 The block SHALL have ports hazard1_i and hazard2_i, input, 2 bits each: operand source selects for operand 1 and operand 2.
REQ-008 The block SHALL have ports id_ir_i (64), id_pc_i (32), id_data1_i (32) and id_data2_i (32), all inputs: the ID-stage instruction, its PC, and the two register-file read values.
REQ-009 The block SHALL have port exe_result_i, input, 32 bits: the result currently in the EXE stage.
REQ-010 The block SHALL have port mem_result_i, input, 32 bits: the result currently in the MEM stage.
REQ-011 The block SHALL have ports exe_ir_o (64), exe_pc_o (32), exe_data1_o (32), exe_data2_o (32) and exe_valid_o (1), all outputs: the ID/EXE stage register contents.
REQ-012 The block SHALL have ports stall_cnt_o and fwd_cnt_o, output, 16 bits each: statistics counters (see Configuration).

Function
REQ-013 The block SHALL decode each hazard select as: 0 = register-file value, 1 = mem_result_i, 2 = exe_result_i, 3 = reserved and treated as 0.
REQ-014 The block SHALL apply the forwarding mux combinationally, before the stage register; forwarded data appears on exe_data*_o exactly 1 cycle after it is presented.
REQ-015 The block SHALL apply a per-edge priority of flush_i, then exe_hold_i, then stall_i, then normal load.
REQ-016 On flush: the block SHALL load a bubble (exe_ir_o=64'h0, exe_pc_o=0, exe_data*_o=0, exe_valid_o=0), including when exe_hold_i is also 1.
REQ-017 On hold: the block SHALL keep every output register unchanged, and stall_i SHALL be ignored that cycle.
REQ-018 On stall: the block SHALL load a bubble identical to REQ-016.
REQ-019 On normal load: the block SHALL capture id_ir_i, id_pc_i and the forwarded operands, and set exe_valid_o=1 if id_ir_i != 64'h0, otherwise 0.
REQ-020 The block SHALL treat an all-zero IR as a NOP everywhere; a NOP entering with nonzero hazard selects still captures the muxed data but does not count as forwarded.
REQ-021 The block SHALL implement a two-state control FSM: RUN (loads or bubbles each edge) and HOLD (frozen); RUN->HOLD when exe_hold_i=1 and flush_i=0; HOLD->RUN when exe_hold_i=0 or flush_i=1; reset state is RUN.
REQ-022 The block SHALL NOT re-sample operands while in HOLD; the operands captured on HOLD entry are retained.

Reset
REQ-023 While rst_i=0 the block SHALL immediately clear all outputs to zero, including exe_valid_o and both counters, and force the FSM to RUN, regardless of clock.
REQ-024 Reset asserted mid-HOLD SHALL discard the held instruction; the first edge after release performs a normal evaluation per REQ-015.

Configuration
REQ-025 The block SHALL support macro FWD_STAGE_STATS_EN: when defined, stall_cnt_o increments on each edge a stall bubble is loaded (REQ-018), and fwd_cnt_o increments on each normal load of a non-NOP with hazard1_i or hazard2_i in {1,2}.
REQ-026 With FWD_STAGE_STATS_EN defined, both counters SHALL saturate at 16'hFFFF and never wrap.
REQ-027 Without FWD_STAGE_STATS_EN, stall_cnt_o and fwd_cnt_o SHALL be constant 0, the ports SHALL remain present, and no counter flops SHALL be inferred.

Verification
REQ-028 The bench SHALL cover: reset released, id_ir_i=64'h1234, data1=5, data2=7, hazards 0/0 -> next edge exe_ir_o=64'h1234, exe_data1_o=5, exe_data2_o=7, exe_valid_o=1.
REQ-029 The bench SHALL cover: hazard1=1, hazard2=2, mem_result_i=0xAA, exe_result_i=0xBB -> exe_data1_o=0xAA, exe_data2_o=0xBB; fwd_cnt_o=1 if FWD_STAGE_STATS_EN is defined, else 0.
REQ-030 The bench SHALL cover: stall_i=1 for 2 cycles with a valid IR -> 2 bubbles (exe_ir_o=0, exe_valid_o=0); stall_cnt_o=2 with stats enabled.
REQ-031 The bench SHALL cover: exe_hold_i=1 for 3 cycles while ID inputs change -> outputs frozen at the pre-hold values; on release, the current ID instruction is loaded.
REQ-032 The bench SHALL cover: flush_i=1 together with exe_hold_i=1 and stall_i=1 -> bubble loaded, FSM in RUN, stall_cnt_o unchanged.
REQ-033 The bench SHALL cover: with stats enabled, preload stall_cnt_o to 16'hFFFE, then apply 3 stall cycles -> 16'hFFFF and held there; then assert rst_i=0 mid-cycle -> all outputs 0 asynchronously.
